// File: rtl/imem_fetch_loader.sv
// rtl/imem_fetch_loader.sv - instruction memory image loader and in-order fetch unit
// Streams a program image into the X/Y memory, then fetches words through a 2-entry buffer.
module imem_fetch_loader #(
    parameter int ADDR_BITS  = 4,
    parameter int DATA_WIDTH = 32,
    localparam int WAW       = 2*ADDR_BITS,
    localparam int PCW       = 2*ADDR_BITS + 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_load_last,
    output logic                  o_load_done,
    output logic [WAW:0]          o_load_count,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_redirect_valid,
    input  logic [PCW-1:0]        i_redirect_pc,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [DATA_WIDTH-1:0] o_inst_data,
    output logic [PCW-1:0]        o_inst_pc,
    output logic                  o_mem_we,
    output logic [ADDR_BITS-1:0]  o_mem_x_addr,
    output logic [ADDR_BITS-1:0]  o_mem_y_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WAW-1:0]        r_ptr;
    logic [WAW:0]          r_load_count;
    logic                  r_load_done;
    logic [PCW-1:0]        r_fetch_pc;
    logic                  r_inflight;
    logic [PCW-1:0]        r_inflight_pc;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic [PCW-1:0]        r_fifo_pc   [2];
    logic [1:0]            r_count;
    logic                  r_rd;

    logic                  w_load_hs;
    logic                  w_load_end;
    logic                  w_flush;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_wr;
    logic [1:0]            w_occ;
    logic [WAW-1:0]        w_waddr;

    assign w_load_hs  = i_load_valid && o_load_ready;
    assign w_load_end = w_load_hs && (i_load_last || (&r_ptr));
    assign w_flush    = (r_state == S_FETCH) && (i_stop || i_redirect_valid);
    assign w_pop      = o_inst_valid && i_inst_ready;
    assign w_occ      = r_count + {1'b0, r_inflight};
    // A slot freed by this cycle's pop may be claimed by a new read issued in the same cycle.
    assign w_issue    = (r_state == S_FETCH) && !w_flush &&
                        ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));
    assign w_wr       = r_rd ^ r_count[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load_hs) begin
                    w_state_next = w_load_end ? S_IDLE : S_LOAD;
                end else if (i_start && !i_stop) begin
                    w_state_next = S_FETCH;
                end
            end
            S_LOAD: begin
                if (w_load_end) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FETCH: begin
                if (i_stop) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_load_ready = !i_rst && (r_state != S_FETCH);
        o_mem_we     = i_load_valid && o_load_ready;
        o_mem_wdata  = i_load_data;
        w_waddr      = (r_state == S_FETCH) ? r_fetch_pc[PCW-1:2] : r_ptr;
        o_mem_x_addr = w_waddr[WAW-1:ADDR_BITS];
        o_mem_y_addr = w_waddr[ADDR_BITS-1:0];
        o_inst_valid = (r_count != 2'd0);
        o_inst_data  = r_fifo_data[r_rd];
        o_inst_pc    = r_fifo_pc[r_rd];
        o_load_done  = r_load_done;
        o_load_count = r_load_count;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr          <= '0;
            r_load_count   <= '0;
            r_load_done    <= 1'b0;
            r_fetch_pc     <= '0;
            r_inflight     <= 1'b0;
            r_inflight_pc  <= '0;
            r_count        <= 2'd0;
            r_rd           <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_pc[0]   <= '0;
            r_fifo_pc[1]   <= '0;
        end else begin
            r_load_done <= w_load_end;
            if (w_load_hs) begin
                r_ptr        <= w_load_end ? '0 : r_ptr + WAW'(1);
                r_load_count <= (r_state == S_IDLE) ? (WAW+1)'(1) : r_load_count + (WAW+1)'(1);
            end

            if ((r_state == S_IDLE) && (w_state_next == S_FETCH)) begin
                r_fetch_pc <= '0;
                r_inflight <= 1'b0;
                r_count    <= 2'd0;
                r_rd       <= 1'b0;
            end else if (w_flush) begin
                r_inflight <= 1'b0;
                r_count    <= 2'd0;
                r_rd       <= 1'b0;
                if (!i_stop) begin
                    r_fetch_pc <= i_redirect_pc & ~PCW'(3);
                end
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_pc <= r_fetch_pc;
                    r_fetch_pc    <= r_fetch_pc + PCW'(4);
                end
                if (r_inflight) begin
                    r_fifo_data[w_wr] <= i_mem_rdata;
                    r_fifo_pc[w_wr]   <= r_inflight_pc;
                end
                r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
                if (w_pop) begin
                    r_rd <= ~r_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_loader.sv
// tb/tb_imem_fetch_loader.sv - scoreboard bench for imem_fetch_loader with a registered-read memory model
module tb_imem_fetch_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_done;
    logic [8:0]  load_count;
    logic        start;
    logic        stop;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [9:0]  inst_pc;
    logic        mem_we;
    logic [3:0]  mem_x_addr;
    logic [3:0]  mem_y_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    imem_fetch_loader #(.ADDR_BITS(4), .DATA_WIDTH(32)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_load_valid    (load_valid),
        .o_load_ready    (load_ready),
        .i_load_data     (load_data),
        .i_load_last     (load_last),
        .o_load_done     (load_done),
        .o_load_count    (load_count),
        .i_start         (start),
        .i_stop          (stop),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_inst_valid    (inst_valid),
        .i_inst_ready    (inst_ready),
        .o_inst_data     (inst_data),
        .o_inst_pc       (inst_pc),
        .o_mem_we        (mem_we),
        .o_mem_x_addr    (mem_x_addr),
        .o_mem_y_addr    (mem_y_addr),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[{mem_x_addr, mem_y_addr}] <= mem_wdata;
        mem_rdata <= mem[{mem_x_addr, mem_y_addr}];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_word(input int k, input logic [31:0] d);
        exp_t e;
        e.pc   = 10'(k * 4);
        e.data = d;
        exp_q.push_back(e);
    endfunction

    // Monitor: every presented instruction must match the queue head; handshake pops it.
    always @(negedge clk) begin
        if (!rst && inst_valid) begin
            if (exp_q.size() > 0) begin
                chk("inst_pc", {22'd0, inst_pc}, {22'd0, exp_q[0].pc});
                chk("inst_data", inst_data, exp_q[0].data);
                if (inst_ready) exp_q.delete(0);
            end else if (inst_ready) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_inst: got pc %h expected no instruction", inst_pc);
            end
        end
    end

    task automatic beat(input logic [31:0] d, input logic last, input int waddr);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(negedge clk);
        chk("mem_we", {31'd0, mem_we}, 32'd1);
        chk("mem_addr", {24'd0, mem_x_addr, mem_y_addr}, 32'(waddr));
        chk("mem_wdata", mem_wdata, d);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget, input bit rnd, input string name);
        int n = 0;
        int stall = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (rnd && stall > 0) begin
                inst_ready = 1'b0;
                stall--;
            end else begin
                inst_ready = 1'b1;
                if (rnd && $urandom_range(0, 2) == 0) stall = int'($urandom_range(1, 7));
            end
            @(posedge clk); #1;
            n++;
        end
        inst_ready = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; stop = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", {22'd0, inst_pc}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_count", {23'd0, load_count}, 32'd0);
        chk("rst_load_ready_after", {31'd0, load_ready}, 32'd1);
        chk("rst_addr", {24'd0, mem_x_addr, mem_y_addr}, 32'd0);
        @(posedge clk); #1;

        // Five-word image terminated by load_last.
        for (int k = 0; k < 5; k++) beat(32'hA0 + 32'(k), k == 4, k);
        load_valid = 1'b0; load_last = 1'b0;
        @(negedge clk);
        chk("load5_done", {31'd0, load_done}, 32'd1);
        chk("load5_count", {23'd0, load_count}, 32'd5);
        chk("load5_ready", {31'd0, load_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("load5_done_pulse", {31'd0, load_done}, 32'd0);
        @(posedge clk); #1;

        // Full image without load_last ends on the last word.
        for (int k = 0; k < 256; k++) beat(32'hA0 + 32'(k), 1'b0, k);
        load_valid = 1'b0;
        @(negedge clk);
        chk("full_done", {31'd0, load_done}, 32'd1);
        chk("full_count", {23'd0, load_count}, 32'd256);
        chk("full_ready", {31'd0, load_ready}, 32'd1);
        @(posedge clk); #1;
        beat(32'hA0, 1'b1, 0);
        load_valid = 1'b0; load_last = 1'b0;
        @(negedge clk);
        chk("reload_count", {23'd0, load_count}, 32'd1);
        chk("reload_done", {31'd0, load_done}, 32'd1);
        @(posedge clk); #1;

        // Unstalled stream through the PC wrap, with start latency.
        for (int k = 0; k < 260; k++) push_word(k, 32'hA0 + 32'(k % 256));
        inst_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("lat_e0_valid", {31'd0, inst_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_e1_valid", {31'd0, inst_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_e2_valid", {31'd0, inst_valid}, 32'd1);
        drain(400, 1'b0, "stream");

        // Continue the same stream with random stalls of 1-7 cycles.
        for (int k = 260; k < 300; k++) push_word(k, 32'hA0 + 32'(k % 256));
        drain(2000, 1'b1, "stall");

        // Redirect to 0x012 drops buffered words and resumes at word 4.
        redirect_valid = 1'b1;
        redirect_pc = 10'h012;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        exp_q.delete();
        for (int k = 4; k < 10; k++) push_word(k, 32'hA0 + 32'(k));
        @(negedge clk);
        chk("redirect_flush_valid", {31'd0, inst_valid}, 32'd0);
        @(posedge clk); #1;
        drain(100, 1'b0, "redirect");

        // Stop and redirect together: stop wins.
        stop = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h100;
        @(posedge clk); #1;
        stop = 1'b0; redirect_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("stop_valid", {31'd0, inst_valid}, 32'd0);
        chk("stop_idle_ready", {31'd0, load_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("stop_valid_later", {31'd0, inst_valid}, 32'd0);
        @(posedge clk); #1;

        // start together with stop in IDLE stays IDLE.
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("startstop_valid", {31'd0, inst_valid}, 32'd0);
        chk("startstop_ready", {31'd0, load_ready}, 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a load.
        beat(32'h111, 1'b0, 0);
        beat(32'h222, 1'b0, 1);
        beat(32'h333, 1'b0, 2);
        rst = 1'b1;
        load_data = 32'hBAD;
        @(negedge clk);
        chk("midrst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        chk("midrst_count", {23'd0, load_count}, 32'd0);
        chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
        chk("midrst_ready", {31'd0, load_ready}, 32'd1);
        @(posedge clk); #1;
        push_word(0, 32'h111);
        push_word(1, 32'h222);
        push_word(2, 32'h333);
        push_word(3, 32'hA3);
        push_word(4, 32'hA4);
        start = 1'b1;
        inst_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain(100, 1'b0, "after_reset");

        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_loader.md
# imem_fetch_loader

Controller that drives the instruction memory's X/Y-addressed port from the CPU side: it streams a program image into the memory after reset, then fetches instruction words in PC order and delivers them to the decoder over a valid/ready handshake. It absorbs the memory's one-cycle registered read latency with a 2-entry buffer, sustains one instruction per cycle, and supports PC redirect and stop.

## Interface
- ADDR_BITS, 4, X and Y address width; memory holds 2^(2*ADDR_BITS) words
- DATA_WIDTH, 32, instruction word width
- PCW (localparam), 2*ADDR_BITS+2, byte PC width
- Clock  in  1  single clock, all logic on posedge
- Reset  in  1  synchronous, active-high
- load_valid  in  1  program-image beat valid
- load_ready  out  1  beat accepted when load_valid && load_ready
- load_data  in  DATA_WIDTH  image word
- load_last  in  1  final beat of image
- load_done  out  1  one-cycle pulse after final beat written
- load_count  out  2*ADDR_BITS+1  words written by last/current load
- start  in  1  begin fetching at PC 0 (IDLE only)
- stop  in  1  end fetching, return to IDLE
- redirect_valid  in  1  jump request (FETCH only)
- redirect_pc  in  PCW  jump target; bits [1:0] ignored
- inst_valid  out  1  inst_data/inst_pc valid
- inst_ready  in  1  decoder accepts
- inst_data  out  DATA_WIDTH  fetched word
- inst_pc  out  PCW  byte PC of inst_data
- mem_we  out  1  to memory WriteEnable
- mem_x_addr  out  ADDR_BITS  word address upper half
- mem_y_addr  out  ADDR_BITS  word address lower half
- mem_wdata  out  DATA_WIDTH  to memory Data_in
- mem_rdata  in  DATA_WIDTH  from memory Data_out (registered, valid the cycle after the address edge)

## Operation
- States: IDLE, LOAD, FETCH. Reset → IDLE.
- Word address W (2*ADDR_BITS bits): mem_x_addr = W[upper half], mem_y_addr = W[lower half].
- load_ready = 1 in IDLE and LOAD, 0 in FETCH and while Reset high. mem_we = load_valid && load_ready (combinational); mem_wdata = load_data; W = load pointer.
- Beat accepted in IDLE: write word 0, load_count := 1, go LOAD (unless it ends the load). Each LOAD beat writes at pointer, pointer++, load_count++.
- Load ends on beat with load_last=1 or beat written at word 2^(2*ADDR_BITS)-1: → IDLE, load_done pulses next cycle, pointer := 0. Beats never wrap.
- start in IDLE with no load handshake that cycle: → FETCH, fetch_pc := 0. start in LOAD/FETCH ignored.
- FETCH: W = fetch_pc[PCW-1:2] when not writing. A read issues in a cycle iff (buffered + in-flight) < 2, or == 2 and inst_valid && inst_ready this cycle; issuing sets in-flight, fetch_pc += 4 modulo 2^PCW (wraps to 0).
- In-flight read captures mem_rdata with its PC into the 2-entry FIFO on the next edge. inst_* present FIFO head; pop on inst_valid && inst_ready.
- redirect_valid in FETCH: FIFO and in-flight discarded, inst_valid = 0 next cycle, fetch_pc := {redirect_pc[PCW-1:2],2'b00}.
- stop: flush as for redirect, → IDLE. stop and redirect same cycle → stop wins. start/stop same cycle in IDLE → stays IDLE.
- Memory contents never altered by reset.

## Timing
- Reset values: inst_valid 0, inst_data 0, inst_pc 0, load_done 0, load_count 0, mem_we 0, load_ready 0 during Reset then 1, mem addresses 0.
- Reset mid-load: pointer and load_count to 0, state IDLE; beat presented in reset cycle not written.
- Write latency: word in memory at the edge ending the handshake cycle.
- Fetch latency: start or redirect sampled at edge E0 → address driven after E0 → mem_rdata valid after E1 → inst_valid high after E2 (2 cycles).
- Throughput: 1 instruction/cycle with inst_ready held high; inst_data/inst_pc stable while inst_valid && !inst_ready.
- No instruction lost or duplicated across stalls of any length.

## Test plan
- Load 5 words 0xA0..0xA4, load_last on beat 5 → mem_we 5 cycles, addresses 0..4, load_done pulse, load_count=5, state IDLE.
- Load full 256 words (ADDR_BITS=4) without load_last → load ends after word 255 (x=0xF,y=0xF), load_count=256; load_ready stays 1 but next beat starts new load at word 0.
- start, inst_ready=1 → inst_valid 2 cycles later, inst_pc 0,4,8,… each cycle with data 0xA0,0xA1,…; PC wraps 0x3FC→0x000.
- Toggle inst_ready randomly (stall 1–7 cycles) → delivered sequence identical to unstalled run, values held during stall.
- redirect_pc=0x012 mid-stream → buffered words dropped, next delivered inst_pc=0x010, data word 4; stop+redirect same cycle → IDLE, inst_valid 0.
- Reset asserted mid-load after 3 beats → load_count 0, load_ready 0 during Reset, words 0..2 retain written data on later fetch.
